data_mem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port; it is the target end of the load/store interface the CPU drives.
- Accepts one load or store request at a time over a valid/ready handshake and models a configurable number of wait states.
- Performs RV32I byte/halfword/word lane selection and sign/zero extension, then returns the result over a valid/ready response channel.
- Replaces the zero-latency combinational data memory so the core can be moved to a stalling/multi-cycle memory model.

---
 rtl/rv_mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// codes, responder state encoding and the latched request record.
package rv_mem_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request captured at the handshake; held unchanged for the whole access
    typedef struct packed {
        logic [31:0] addr;
        logic        w_en;
        logic [31:0] w_data;
        logic [2:0]  funct3;
    } mem_req_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W
    function automatic logic f3_legal(input logic [2:0] funct3, input logic w_en);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !w_en;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for RV32I sub-word accesses: byte enables and
// lane-shifted store data, extracted/extended load data, and a flag for
// misaligned addresses or illegal funct3 codes. Little-endian lanes.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        w_en,
    input  logic [31:0] w_data,
    input  logic [31:0] r_word,
    output logic [3:0]  byte_en,
    output logic [31:0] w_lane,
    output logic [31:0] r_ext,
    output logic        lane_err
);

    logic [7:0]  rb;
    logic [15:0] rh;

    // Addressed byte and halfword of the read word
    assign rb = r_word[{addr_lo, 3'b000} +: 8];
    assign rh = r_word[{addr_lo[1], 4'b0000} +: 16];

    // Decode width, check alignment, steer store lanes and extend load data
    always_comb begin
        byte_en  = 4'b0000;
        w_lane   = 32'h0;
        r_ext    = 32'h0;
        lane_err = !f3_legal(funct3, w_en);
        case (funct3)
            F3_B: begin
                byte_en = 4'b0001 << addr_lo;
                w_lane  = {24'h0, w_data[7:0]} << {addr_lo, 3'b000};
                r_ext   = {{24{rb[7]}}, rb};
            end
            F3_BU: begin
                r_ext = {24'h0, rb};
            end
            F3_H: begin
                lane_err = lane_err | addr_lo[0];
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                w_lane   = addr_lo[1] ? {w_data[15:0], 16'h0} : {16'h0, w_data[15:0]};
                r_ext    = {{16{rh[15]}}, rh};
            end
            F3_HU: begin
                lane_err = lane_err | addr_lo[0];
                r_ext    = {16'h0, rh};
            end
            F3_W: begin
                lane_err = lane_err | (addr_lo != 2'b00);
                byte_en  = 4'b1111;
                w_lane   = w_data;
                r_ext    = r_word;
            end
            default: ;
        endcase
        // Only a legal store drives byte enables
        if (lane_err || !w_en) byte_en = 4'b0000;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access against a word array with byte enables and
// returns the (extended) result on a valid/ready response channel.
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_w_en,
    input  logic [31:0] req_w_data,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_r_data,
    output logic        rsp_error
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    state_t     state;
    mem_req_t   req_q;
    logic [3:0] cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [3:0]       byte_en;
    logic [31:0]      st_lane;
    logic [31:0]      ld_data;
    logic             lane_err;
    logic             in_range;
    logic             acc_err;
    logic             do_access;

    assign idx       = req_q.addr[IDX_W+1:2];
    assign rd_word   = mem[idx];
    assign in_range  = ({1'b0, req_q.addr} < LIMIT);
    assign acc_err   = lane_err | !in_range;
    // The access happens on the edge that moves WAIT to RESP, i.e. the
    // (LATENCY+1)-th edge after acceptance; LATENCY=0 spends one cycle in WAIT.
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    mem_lane_align u_align (
        .addr_lo  (req_q.addr[1:0]),
        .funct3   (req_q.funct3),
        .w_en     (req_q.w_en),
        .w_data   (req_q.w_data),
        .r_word   (rd_word),
        .byte_en  (byte_en),
        .w_lane   (st_lane),
        .r_ext    (ld_data),
        .lane_err (lane_err)
    );

    // Request/response FSM with wait-state counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_r_data <= 32'h0;
            rsp_error  <= 1'b0;
            cnt        <= 4'd0;
            req_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q     <= '{addr: req_addr, w_en: req_w_en,
                                       w_data: req_w_data, funct3: req_funct3};
                        cnt       <= LAT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_valid  <= 1'b1;
                        rsp_error  <= acc_err;
                        rsp_r_data <= (acc_err || req_q.w_en) ? 32'h0 : ld_data;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response is held until taken; no new request overlaps it
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_r_data <= 32'h0;
                        rsp_error  <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage write: byte-enabled commit on the access edge; never cleared,
    // and a reset on the commit edge suppresses the write
    always_ff @(posedge clock) begin
        if (!reset && do_access && req_q.w_en && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= st_lane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-level reference model
// predicts each response when the request is accepted; a monitor compares
// responses and their latency as they are handed over.
module tb_data_mem_responder;
    import rv_mem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int LAT    = 2;
    localparam int DEPTH0 = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_addr = '0, req_w_data = '0;
    logic        req_w_en = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
    logic [31:0] rsp_r_data;

    logic        req_valid0 = 1'b0, req_ready0;
    logic [31:0] req_addr0 = '0, req_w_data0 = '0;
    logic        req_w_en0 = 1'b0;
    logic [2:0]  req_funct30 = '0;
    logic        rsp_valid0, rsp_ready0 = 1'b1, rsp_error0;
    logic [31:0] rsp_r_data0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_w_en(req_w_en), .req_w_data(req_w_data), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r_data(rsp_r_data), .rsp_error(rsp_error)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .req_w_en(req_w_en0), .req_w_data(req_w_data0), .req_funct3(req_funct30),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_r_data(rsp_r_data0), .rsp_error(rsp_error0)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit force_mode = 1'b1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [7:0] ref_mem [DEPTH*4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: memory as a flat byte array, widths from funct3 arithmetic
    function automatic void model(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] d, output logic e);
        int     nb;
        bit     legal;
        longint v;
        nb    = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e     = !legal || ((a % nb) != 0) || (a >= DEPTH*4);
        d     = 32'h0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[a+i]) << (8*i));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
            d = v[31:0];
        end
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [2:0] f3, input int t);
        logic [31:0] d;
        logic        e;
        model(a, we, wd, f3, d, e);
        exp_q.push_back('{d, e, t + 1 + LAT});
    endtask

    task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [2:0] f3);
        int n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_addr = a; req_w_en = we; req_w_data = wd; req_funct3 = f3;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        push_exp(a, we, wd, f3, cyc);
        @(negedge clock);
        // Scramble the idle request fields; the DUT must ignore them now
        req_valid = 1'b0; req_addr = $urandom; req_w_data = $urandom;
        req_funct3 = 3'($urandom); req_w_en = 1'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clock); n++; end
        if (exp_q.size() != 0) check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic issue0(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        int t;
        @(negedge clock);
        req_valid0 = 1'b1; req_addr0 = a; req_w_en0 = we; req_w_data0 = wd; req_funct30 = f3;
        check("lat0_req_ready", 32'(req_ready0), 32'd1);
        @(posedge clock); #1;
        t = cyc;
        @(negedge clock);
        req_valid0 = 1'b0;
        while (!rsp_valid0 && n < 20) begin @(negedge clock); n++; end
        check("lat0_latency", 32'(cyc), 32'(t + 1));
        check("lat0_rsp_r_data", rsp_r_data0, exp_d);
        check("lat0_rsp_error", 32'(rsp_error0), 32'(exp_e));
    endtask

    // Random response backpressure unless a directed phase owns rsp_ready
    initial forever begin
        @(negedge clock);
        if (!force_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on each new response, data/error on each handshake
    logic prev_v = 1'b0;
    always @(negedge clock) begin
        #1;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                else                   check("rsp_latency", 32'(cyc), 32'(exp_q[0].cyc));
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("rsp_r_data", rsp_r_data, mon_e.d);
                check("rsp_error", 32'(rsp_error), 32'(mon_e.e));
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a, sd;
        logic [2:0]  f3;
        logic        we;

        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clock);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_r_data", rsp_r_data, 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b0;

        // Known contents for every word the test touches
        for (int w = 0; w < 16; w++) issue(32'(w*4), 1'b1, 32'h0, F3_W);
        issue(32'(DEPTH*4 - 4), 1'b1, 32'h0, F3_W);

        // Directed lane/extension/error cases
        issue(32'h10, 1'b1, 32'hDEADBEEF, F3_W);
        issue(32'h10, 1'b0, 32'h0, F3_W);
        issue(32'h13, 1'b0, 32'h0, F3_B);
        issue(32'h13, 1'b0, 32'h0, F3_BU);
        issue(32'h10, 1'b0, 32'h0, F3_H);
        issue(32'h12, 1'b0, 32'h0, F3_HU);
        issue(32'h11, 1'b1, 32'h000000AA, F3_B);
        issue(32'h10, 1'b0, 32'h0, F3_W);
        issue(32'h12, 1'b0, 32'h0, F3_W);
        issue(32'h11, 1'b1, 32'h00001234, F3_H);
        issue(32'h10, 1'b0, 32'h0, F3_W);
        issue(32'(DEPTH*4), 1'b0, 32'h0, F3_W);
        issue(32'h14, 1'b0, 32'h0, 3'b011);
        issue(32'h14, 1'b1, 32'h55555555, F3_BU);

        force_mode = 1'b0;
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH*4 - 4 + $urandom_range(0, 7));
            else                           a = 32'($urandom_range(0, 63));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? F3_BU : F3_W);
            issue(a, we, $urandom, f3);
        end
        wait_drain("drain_random");

        // Backpressure: response held, no request accepted until after handshake
        force_mode = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        issue(32'h10, 1'b0, 32'h0, F3_W);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clock); n++; end
        sd = (exp_q.size() != 0) ? exp_q[0].d : 32'hXXXXXXXX;
        req_valid = 1'b1; req_addr = 32'h14; req_w_en = 1'b0; req_funct3 = F3_W;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_r_data", rsp_r_data, sd);
            check("stall_rsp_error", 32'(rsp_error), 32'd0);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        push_exp(32'h14, 1'b0, 32'h0, F3_W, cyc);
        @(negedge clock);
        req_valid = 1'b0;
        wait_drain("drain_stall");

        // Reset in WAIT abandons an uncommitted store
        issue(32'h20, 1'b1, 32'h0, F3_W);
        wait_drain("drain_pre_reset");
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h20; req_w_en = 1'b1; req_w_data = 32'h12345678; req_funct3 = F3_W;
        check("rst_test_req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("wait_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("wait_reset_req_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clock);
        check("abandoned_rsp_valid", 32'(rsp_valid), 32'd0);
        issue(32'h20, 1'b0, 32'h0, F3_W);
        wait_drain("drain_reset");
        force_mode = 1'b0;

        // LATENCY=0 instance: response one edge after acceptance
        issue0(32'h8, 1'b1, 32'hCAFEF00D, F3_W, 32'h0, 1'b0);
        issue0(32'h8, 1'b0, 32'h0, F3_W, 32'hCAFEF00D, 1'b0);
        issue0(32'hA, 1'b0, 32'h0, F3_H, 32'hFFFFCAFE, 1'b0);
        issue0(32'(DEPTH0*4), 1'b0, 32'h0, F3_W, 32'h0, 1'b1);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
